// File: rtl/regbank_wr_sched_if.sv
// ---------------------------------------------------------------------------
// regbank_wr_sched_if
//   Bundles the requester-facing write request bus and the register-bank
//   write-port outputs of regbank_wr_sched.
//
//   Request side (driven by requesters / bench):
//     req_in   [NUMREQ]            level request, held until ack
//     pair_in  [NUMREQ]            1 = 16-bit pair write, 0 = single register
//     addr_in  [NUMREQ*3]          3-bit register/pair code per requester
//     data_in  [NUMREQ*2*DATASIZE] {high byte, low byte} per requester
//   Scheduler side (driven by regbank_wr_sched):
//     ack_out  [NUMREQ]            one-cycle accept pulse
//     err_out                      one-cycle pulse with ack on invalid request
//     busy_out                     write sequence in progress
//     enb_out  [8]                 one-hot register enable by register code
//     data_out [DATASIZE]          shared register write data
// ---------------------------------------------------------------------------
interface regbank_wr_sched_if #(
  parameter int DATASIZE = 8,
  parameter int NUMREQ   = 3
);
  logic [NUMREQ-1:0]            req_in;
  logic [NUMREQ-1:0]            pair_in;
  logic [NUMREQ*3-1:0]          addr_in;
  logic [NUMREQ*2*DATASIZE-1:0] data_in;
  logic [NUMREQ-1:0]            ack_out;
  logic                         err_out;
  logic                         busy_out;
  logic [7:0]                   enb_out;
  logic [DATASIZE-1:0]          data_out;

  // requester side
  modport master (
    output req_in, pair_in, addr_in, data_in,
    input  ack_out, err_out, busy_out, enb_out, data_out
  );

  // scheduler side
  modport slave (
    input  req_in, pair_in, addr_in, data_in,
    output ack_out, err_out, busy_out, enb_out, data_out
  );
endinterface

// File: rtl/regbank_wr_sched.sv
// ---------------------------------------------------------------------------
// regbank_wr_sched
//   Write-port scheduler for the general register bank (B,C,D,E,H,L,A).
//   Several datapath sources (ALU, internal bus latch, inc/dec unit) share
//   the single bank write path. One requester is granted per decision; a
//   single write takes one write cycle, a BC/DE/HL pair write takes two
//   back-to-back byte writes (high byte to B/D/H, then low byte to C/E/L).
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   regbank_wr_sched_if.slave (request bus in, enables/data out)
//
//   Parameters:
//     DATASIZE  register width (multiple of 4), default 8
//     NUMREQ    number of requesters (2..8), default 3
//
//   Build option:
//     REGSCHED_FIXPRI_EN  defined   -> fixed priority, lowest index wins,
//                                      no round-robin pointer
//                         undefined -> round-robin starting after the last
//                                      granted requester
//
//   All outputs are registered. Grant decision happens in IDLE; WR1 output
//   values are computed from the winner's live inputs in that same cycle and
//   registered, so ack and the first enable appear one cycle after the
//   request is sampled.
// ---------------------------------------------------------------------------

// Per-requester decode: validity and the enables/data each write would use.
module regbank_wr_sched_lane #(
  parameter int DATASIZE = 8
) (
  input  logic                  pair,
  input  logic [2:0]            addr,
  input  logic [2*DATASIZE-1:0] data,
  output logic                  valid,
  output logic                  has_second,
  output logic [7:0]            enb_first,
  output logic [7:0]            enb_second,
  output logic [DATASIZE-1:0]   data_first,
  output logic [DATASIZE-1:0]   data_lo
);
  logic [DATASIZE-1:0] data_hi;

  assign data_hi = data[2*DATASIZE-1:DATASIZE];
  assign data_lo = data[DATASIZE-1:0];

  // code 6 is the memory operand M, pair code 3 would be SP/PSW: neither
  // lives in this bank
  assign valid      = pair ? (addr[2:1] != 2'b11) : (addr != 3'd6);
  assign has_second = pair & valid;

  // pair writes: {pair,0} is B/D/H (high byte), {pair,1} is C/E/L (low byte)
  assign enb_first  = pair ? (8'd1 << {addr[2:1], 1'b0}) : (8'd1 << addr);
  assign enb_second = 8'd1 << {addr[2:1], 1'b1};
  assign data_first = pair ? data_hi : data_lo;
endmodule

module regbank_wr_sched #(
  parameter int DATASIZE = 8,
  parameter int NUMREQ   = 3
) (
  input  logic               clk,
  input  logic               rst,
  regbank_wr_sched_if.slave  bus
);
  localparam int IW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;

  typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;

  state_t state_q, state_d;

  // registered outputs
  logic [NUMREQ-1:0]   ack_q,  ack_d;
  logic                err_q,  err_d;
  logic                busy_q, busy_d;
  logic [7:0]          enb_q,  enb_d;
  logic [DATASIZE-1:0] data_q, data_d;

  // second-byte context latched at the grant decision
  logic                has2_q;
  logic [7:0]          enb2_q;
  logic [DATASIZE-1:0] lo_q;

  // lane decode
  logic [NUMREQ-1:0]                lane_valid;
  logic [NUMREQ-1:0]                lane_has2;
  logic [NUMREQ-1:0][7:0]           lane_enb1;
  logic [NUMREQ-1:0][7:0]           lane_enb2;
  logic [NUMREQ-1:0][DATASIZE-1:0]  lane_d1;
  logic [NUMREQ-1:0][DATASIZE-1:0]  lane_lo;

  logic          any_req;
  logic [IW-1:0] win;

  for (genvar g = 0; g < NUMREQ; g++) begin : g_lane
    regbank_wr_sched_lane #(.DATASIZE(DATASIZE)) u_lane (
      .pair       (bus.pair_in[g]),
      .addr       (bus.addr_in[3*g +: 3]),
      .data       (bus.data_in[2*DATASIZE*g +: 2*DATASIZE]),
      .valid      (lane_valid[g]),
      .has_second (lane_has2[g]),
      .enb_first  (lane_enb1[g]),
      .enb_second (lane_enb2[g]),
      .data_first (lane_d1[g]),
      .data_lo    (lane_lo[g])
    );
  end

  assign any_req = |bus.req_in;

`ifdef REGSCHED_FIXPRI_EN
  // lowest active index wins; scan downward so the last hit is the lowest
  always_comb begin
    win = '0;
    for (int i = NUMREQ - 1; i >= 0; i--) begin
      if (bus.req_in[IW'(i)]) win = IW'(i);
    end
  end
`else
  logic [IW-1:0] rr_q;

  // search starts one past the last winner and wraps
  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    win   = rr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUMREQ; k++) begin
      idx = IW'((int'(rr_q) + k) % NUMREQ);
      if (!found && bus.req_in[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                            rr_q <= IW'(NUMREQ - 1);
    else if (state_q == IDLE && any_req) rr_q <= win;
  end
`endif

  // next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    err_d   = 1'b0;
    busy_d  = 1'b0;
    enb_d   = '0;
    data_d  = data_q;   // write bus holds its value between writes
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = WR1;
          ack_d[win] = 1'b1;
          busy_d     = 1'b1;
          if (lane_valid[win]) begin
            enb_d  = lane_enb1[win];
            data_d = lane_d1[win];
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      WR1: begin
        if (has2_q) begin
          state_d = WR2;
          enb_d   = enb2_q;
          data_d  = lo_q;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WR2:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      enb_q   <= '0;
      data_q  <= '0;
      has2_q  <= 1'b0;
      enb2_q  <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      enb_q   <= enb_d;
      data_q  <= data_d;
      if (state_q == IDLE && any_req) begin
        has2_q <= lane_has2[win];
        enb2_q <= lane_enb2[win];
        lo_q   <= lane_lo[win];
      end
    end
  end

  assign bus.ack_out  = ack_q;
  assign bus.err_out  = err_q;
  assign bus.busy_out = busy_q;
  assign bus.enb_out  = enb_q;
  assign bus.data_out = data_q;
endmodule

// File: tb/tb_regbank_wr_sched.sv
// ---------------------------------------------------------------------------
// tb_regbank_wr_sched
//   Scoreboard bench for regbank_wr_sched (DATASIZE=8, NUMREQ=3). Each grant
//   pushes its expected write-port cycles; a negedge monitor pops one entry
//   for every cycle the DUT shows ack/err/enb activity. Scenario tasks add
//   inline latency and idle-state checks.
// ---------------------------------------------------------------------------
module tb_regbank_wr_sched;
  localparam int DS = 8;
  localparam int NR = 3;

  typedef struct {
    logic [NR-1:0] ack;
    logic          err;
    logic          busy;
    logic [7:0]    enb;
    logic [DS-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regbank_wr_sched_if #(.DATASIZE(DS), .NUMREQ(NR)) bus ();
  regbank_wr_sched #(.DATASIZE(DS), .NUMREQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ev_t           sbq[$];
  ev_t           mon_e;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DS-1:0] m_data;   // model of the held write-bus value

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every active write-port cycle must match the next expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.ack_out != '0 || bus.enb_out != '0 || bus.err_out)) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: ack=%b err=%b enb=%h data=%h, required no activity",
                 bus.ack_out, bus.err_out, bus.enb_out, bus.data_out);
      end else begin
        mon_e = sbq.pop_front();
        if (bus.ack_out !== mon_e.ack || bus.err_out !== mon_e.err || bus.busy_out !== mon_e.busy ||
            bus.enb_out !== mon_e.enb || bus.data_out !== mon_e.data) begin
          errors++;
          $display("FAIL sb_write: got ack=%b err=%b busy=%b enb=%h data=%h, required ack=%b err=%b busy=%b enb=%h data=%h",
                   bus.ack_out, bus.err_out, bus.busy_out, bus.enb_out, bus.data_out,
                   mon_e.ack, mon_e.err, mon_e.busy, mon_e.enb, mon_e.data);
        end
      end
    end
  end

  // expected register codes for a pair: {high, low}
  function automatic logic [5:0] pair_codes(input logic [1:0] p);
    case (p)
      2'd0:    return {3'd0, 3'd1};  // B, C
      2'd1:    return {3'd2, 3'd3};  // D, E
      default: return {3'd4, 3'd5};  // H, L
    endcase
  endfunction

  // model of one accepted grant
  task automatic push_grant(input int idx, input logic pair, input logic [2:0] addr,
                            input logic [15:0] d);
    ev_t        e;
    logic       ok;
    logic [5:0] pc;
    ok = pair ? (addr[2:1] != 2'b11) : (addr != 3'd6);
    pc = pair_codes(addr[2:1]);
    e.ack = '0;
    e.ack[idx] = 1'b1;
    e.err  = !ok;
    e.busy = 1'b1;
    e.enb  = '0;
    if (!ok) begin
      e.data = m_data;
    end else if (pair) begin
      e.enb[pc[5:3]] = 1'b1;
      e.data = d[15:8];
    end else begin
      e.enb[addr] = 1'b1;
      e.data = d[7:0];
    end
    m_data = e.data;
    sbq.push_back(e);
    if (pair && ok) begin
      e.ack = '0;
      e.err = 1'b0;
      e.enb = '0;
      e.enb[pc[2:0]] = 1'b1;
      e.data = d[7:0];
      m_data = e.data;
      sbq.push_back(e);
    end
  endtask

  task automatic set_req(input int idx, input logic on, input logic pair,
                         input logic [2:0] addr, input logic [15:0] d);
    bus.req_in[idx]          = on;
    bus.pair_in[idx]         = pair;
    bus.addr_in[3*idx +: 3]  = addr;
    bus.data_in[16*idx +: 16] = d;
  endtask

  task automatic wait_ack(input int idx, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.ack_out[idx] === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_in  = '0;
    bus.pair_in = '0;
    bus.addr_in = '0;
    bus.data_in = '0;
    m_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ack_out !== '0 || bus.err_out !== 1'b0 || bus.busy_out !== 1'b0 ||
        bus.enb_out !== '0 || bus.data_out !== '0) begin
      errors++;
      $display("FAIL reset_state: ack=%b err=%b busy=%b enb=%h data=%h, required all zero",
               bus.ack_out, bus.err_out, bus.busy_out, bus.enb_out, bus.data_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int t0, t;
    bit ok;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 3'd7, 16'h00A5);
    push_grant(0, 1'b0, 3'd7, 16'h00A5);
    t0 = cyc;
    wait_ack(0, t, ok);
    set_req(0, 1'b0, 1'b0, 3'd7, 16'h00A5);
    checks++;
    if (!ok || t != t0 + 1) begin
      errors++;
      $display("FAIL single_latency: ack at cycle %0d, required %0d", t, t0 + 1);
    end
    @(negedge clk);
    checks++;
    if (bus.enb_out !== '0 || bus.busy_out !== 1'b0 || bus.data_out !== 8'hA5) begin
      errors++;
      $display("FAIL single_after: enb=%h busy=%b data=%h, required enb=00 busy=0 data=a5",
               bus.enb_out, bus.busy_out, bus.data_out);
    end
  endtask

  task automatic test_pair();
    int t;
    bit ok;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 3'b100, 16'h1234);
    push_grant(0, 1'b1, 3'b100, 16'h1234);
    wait_ack(0, t, ok);
    set_req(0, 1'b0, 1'b0, 3'b000, 16'h0000);
    checks++;
    if (!ok || bus.enb_out !== 8'h10 || bus.data_out !== 8'h12) begin
      errors++;
      $display("FAIL pair_wr1: enb=%h data=%h, required enb=10 data=12", bus.enb_out, bus.data_out);
    end
    @(negedge clk);
    checks++;
    if (bus.enb_out !== 8'h20 || bus.data_out !== 8'h34 || bus.busy_out !== 1'b1 || bus.ack_out !== '0) begin
      errors++;
      $display("FAIL pair_wr2: enb=%h data=%h busy=%b ack=%b, required enb=20 data=34 busy=1 ack=000",
               bus.enb_out, bus.data_out, bus.busy_out, bus.ack_out);
    end
    @(negedge clk);
    checks++;
    if (bus.busy_out !== 1'b0 || bus.enb_out !== '0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL pair_done: busy=%b enb=%h pending=%0d, required busy=0 enb=00 pending=0",
               bus.busy_out, bus.enb_out, sbq.size());
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  a[NR];
    logic [15:0] d[NR];
    int rr, w, prev, got;
    bit seen;
    a[0] = 3'd0; d[0] = 16'h0011;
    a[1] = 3'd2; d[1] = 16'h0022;
    a[2] = 3'd7; d[2] = 16'h0033;
    do_reset();
    rr = NR - 1;
    for (int n = 0; n < 6; n++) begin
`ifdef REGSCHED_FIXPRI_EN
      w = 0;
`else
      w = (rr + 1) % NR;
`endif
      rr = w;
      push_grant(w, 1'b0, a[w], d[w]);
    end
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, a[i], d[i]);
    prev = -1;
    for (int n = 0; n < 6; n++) begin
      seen = 1'b0;
      got = -1;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (bus.ack_out != '0) begin
          seen = 1'b1;
          got = cyc;
        end
      end
      checks++;
      if (!seen || (prev >= 0 && got - prev != 2)) begin
        errors++;
        $display("FAIL rr_spacing: grant %0d at cycle %0d after %0d, required spacing 2", n, got, prev);
      end
      prev = got;
    end
    bus.req_in = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: %0d writes pending, required 0", sbq.size());
    end
  endtask

  task automatic test_invalid();
    int t;
    bit ok;
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 3'd6, 16'h0077);
    push_grant(1, 1'b0, 3'd6, 16'h0077);
    wait_ack(1, t, ok);
    set_req(1, 1'b0, 1'b0, 3'd0, 16'h0000);
    checks++;
    if (!ok || bus.ack_out !== 3'b010 || bus.err_out !== 1'b1 || bus.enb_out !== '0) begin
      errors++;
      $display("FAIL invalid_m: ack=%b err=%b enb=%h, required ack=010 err=1 enb=00",
               bus.ack_out, bus.err_out, bus.enb_out);
    end
    repeat (2) @(negedge clk);
    set_req(1, 1'b1, 1'b1, 3'b111, 16'h5566);
    push_grant(1, 1'b1, 3'b111, 16'h5566);
    wait_ack(1, t, ok);
    set_req(1, 1'b0, 1'b0, 3'd0, 16'h0000);
    checks++;
    if (!ok || bus.err_out !== 1'b1 || bus.enb_out !== '0) begin
      errors++;
      $display("FAIL invalid_pair: err=%b enb=%h, required err=1 enb=00", bus.err_out, bus.enb_out);
    end
    @(negedge clk);
    checks++;
    if (bus.enb_out !== '0 || bus.busy_out !== 1'b0 || bus.data_out !== m_data) begin
      errors++;
      $display("FAIL invalid_after: enb=%h busy=%b data=%h, required enb=00 busy=0 data=%h",
               bus.enb_out, bus.busy_out, bus.data_out, m_data);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    bit ok;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 3'b010, 16'hBEEF);
    push_grant(0, 1'b1, 3'b010, 16'hBEEF);
    void'(sbq.pop_back());  // reset during WR1 cancels the E write
    wait_ack(0, t, ok);
    set_req(0, 1'b0, 1'b0, 3'd0, 16'h0000);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!ok || bus.enb_out !== '0 || bus.busy_out !== 1'b0 || bus.data_out !== '0 || bus.ack_out !== '0) begin
      errors++;
      $display("FAIL reset_mid: enb=%h busy=%b data=%h ack=%b, required all zero",
               bus.enb_out, bus.busy_out, bus.data_out, bus.ack_out);
    end
    rst = 1'b0;
    m_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_drain: %0d writes pending, required 0", sbq.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0, t2;
    bit ok0, ok2;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 3'b100, 16'hCAFE);
    push_grant(0, 1'b1, 3'b100, 16'hCAFE);
    wait_ack(0, t0, ok0);
    set_req(0, 1'b0, 1'b0, 3'd0, 16'h0000);
    set_req(2, 1'b1, 1'b0, 3'd3, 16'h0042);
    push_grant(2, 1'b0, 3'd3, 16'h0042);
    wait_ack(2, t2, ok2);
    set_req(2, 1'b0, 1'b0, 3'd0, 16'h0000);
    checks++;
    if (!ok0 || !ok2 || t2 != t0 + 3) begin
      errors++;
      $display("FAIL back_to_back: req2 ack at cycle %0d, required %0d", t2, t0 + 3);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0 || bus.busy_out !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_drain: pending=%0d busy=%b, required 0 and 0", sbq.size(), bus.busy_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_round_robin();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
